dds_sine_gen: RTL and testbench



---
 rtl/dds_pkg.sv | 24 ++
 rtl/counter_6bit.sv | 25 ++
 rtl/mux_2to1_6bit.sv | 18 +
 rtl/mux_2to1_8bit.sv | 18 +
 rtl/dds_sine_gen.sv | 75 +++++++
 tb/tb_dds_sine_gen.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/dds_pkg.sv
// Shared widths, constants and quarter-wave sine table for the DDS sine source.
package dds_pkg;

    localparam int IDX_W     = 6;
    localparam int QUAD_W    = 2;
    localparam int OUT_W     = 8;
    localparam int LUT_DEPTH = 64;

    localparam logic [OUT_W-1:0] MID  = 8'd128;
    localparam logic [IDX_W-1:0] PEAK = 6'd63;

    // round(63*sin(pi/2*k/64)), k = 0..63
    localparam logic [IDX_W-1:0] SINE_LUT [LUT_DEPTH] = '{
        6'd0,  6'd2,  6'd3,  6'd5,  6'd6,  6'd8,  6'd9,  6'd11,
        6'd12, 6'd14, 6'd15, 6'd17, 6'd18, 6'd20, 6'd21, 6'd23,
        6'd24, 6'd26, 6'd27, 6'd28, 6'd30, 6'd31, 6'd32, 6'd34,
        6'd35, 6'd36, 6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43,
        6'd45, 6'd46, 6'd47, 6'd48, 6'd49, 6'd50, 6'd51, 6'd52,
        6'd52, 6'd53, 6'd54, 6'd55, 6'd56, 6'd56, 6'd57, 6'd58,
        6'd58, 6'd59, 6'd59, 6'd60, 6'd60, 6'd61, 6'd61, 6'd61,
        6'd62, 6'd62, 6'd62, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63
    };

endpackage

// File: rtl/counter_6bit.sv
// Free-running 6-bit up-counter with a carry flag raised on the terminal count.
module counter_6bit
    import dds_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] par_out,
    output logic             wrap
);

    logic [IDX_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign par_out = count_reg;
    // High while the count is 63, so the next edge is the 63->0 wrap.
    assign wrap    = &count_reg;

endmodule

// File: rtl/mux_2to1_6bit.sv
// 6-bit 2:1 multiplexer; SM=1 selects b.
module mux_2to1_6bit
    import dds_pkg::*;
(
    input  logic             SM,
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    output logic [IDX_W-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_bit
            assign out[gi] = SM ? b[gi] : a[gi];
        end
    endgenerate

endmodule

// File: rtl/mux_2to1_8bit.sv
// 8-bit 2:1 multiplexer; SM=1 selects b.
module mux_2to1_8bit
    import dds_pkg::*;
(
    input  logic             SM,
    input  logic [OUT_W-1:0] a,
    input  logic [OUT_W-1:0] b,
    output logic [OUT_W-1:0] out
);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign out[gi] = SM ? b[gi] : a[gi];
        end
    endgenerate

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source: 8-bit phase drives a folded quarter-wave ROM, offset-binary output.
module dds_sine_gen
    import dds_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] Magnitude
);

    logic [IDX_W-1:0]  idx;
    logic              idx_wrap;
    logic [QUAD_W-1:0] quad_reg;
    logic [IDX_W-1:0]  idx_neg;
    logic [IDX_W-1:0]  rom_addr;
    logic              idx_zero;
    logic              peak_fix;
    logic [IDX_W-1:0]  rom_val;
    logic [OUT_W-1:0]  twice_val;
    logic [OUT_W-1:0]  pos_sample;
    logic [OUT_W-1:0]  neg_sample;
    logic [OUT_W-1:0]  magnitude_next;
    logic [OUT_W-1:0]  magnitude_reg;

    counter_6bit u_idx (
        .clk     (clk),
        .rst     (rst),
        .par_out (idx),
        .wrap    (idx_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            quad_reg <= '0;
        end else if (idx_wrap) begin
            quad_reg <= quad_reg + 1'b1;
        end
    end

    // Odd quadrants read the table backwards: address (64 - idx) mod 64.
    assign idx_neg = ~idx + 1'b1;

    mux_2to1_6bit u_addr_mux (
        .SM  (quad_reg[0]),
        .a   (idx),
        .b   (idx_neg),
        .out (rom_addr)
    );

    // Backward read at idx=0 would need lut[64]; substitute the peak instead.
    assign idx_zero = ~|idx;
    assign peak_fix = idx_zero & quad_reg[0];
    assign rom_val  = peak_fix ? PEAK : SINE_LUT[rom_addr];

    assign twice_val  = {1'b0, rom_val, 1'b0};
    assign pos_sample = MID + twice_val;
    assign neg_sample = MID - twice_val;

    mux_2to1_8bit u_sign_mux (
        .SM  (quad_reg[1]),
        .a   (pos_sample),
        .b   (neg_sample),
        .out (magnitude_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            magnitude_reg <= MID;
        end else begin
            magnitude_reg <= magnitude_next;
        end
    end

    assign Magnitude = magnitude_reg;

endmodule

// File: tb/tb_dds_sine_gen.sv
// Scoreboard bench for dds_sine_gen against a trig-based model of the sine rules.
module tb_dds_sine_gen;

    typedef struct {
        int exp_val;
        int phase;   // -1 when the edge was a reset edge
    } item_t;

    logic       clk;
    logic       rst;
    logic [7:0] magnitude;

    item_t sb_q[$];
    int    vectors;
    int    miscompares;
    int    model_p;
    int    obs[256];
    bit    have_obs[256];

    dds_sine_gen dut (
        .clk       (clk),
        .rst       (rst),
        .Magnitude (magnitude)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lut_model(input int k);
        real x;
        x = 63.0 * $sin(3.14159265358979 * real'(k) / 128.0);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int f_model(input int p);
        int q;
        int i;
        q = p / 64;
        i = p % 64;
        case (q)
            0:       return 128 + 2 * lut_model(i);
            1:       return (i == 0) ? 254 : 128 + 2 * lut_model(64 - i);
            2:       return 128 - 2 * lut_model(i);
            default: return (i == 0) ? 2 : 128 - 2 * lut_model(64 - i);
        endcase
    endfunction

    // Drive rst for the coming edge and queue what that edge must produce.
    task automatic step(input logic r);
        item_t it;
        rst = r;
        if (r) begin
            it.exp_val = 128;
            it.phase   = -1;
            model_p    = 0;
        end else begin
            it.exp_val = f_model(model_p);
            it.phase   = model_p;
            model_p    = (model_p + 1) % 256;
        end
        sb_q.push_back(it);
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: one popped expectation per clock edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                vectors++;
                if (int'(magnitude) != it.exp_val) begin
                    miscompares++;
                    $display("FAIL mag phase=%0d got %0d expected %0d", it.phase, magnitude, it.exp_val);
                end else begin
                    $display("vec phase=%0d mag=%0d", it.phase, magnitude);
                end
                if (it.phase >= 0) begin
                    if (have_obs[it.phase]) begin
                        check("period", int'(magnitude), obs[it.phase]);
                    end else begin
                        obs[it.phase]      = int'(magnitude);
                        have_obs[it.phase] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_p     = 0;
        for (int k = 0; k < 256; k++) begin
            have_obs[k] = 1'b0;
            obs[k]      = 0;
        end

        step(1'b1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            step(1'b1);
        end
        // Two full periods and change, uninterrupted.
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            step(1'b0);
        end
        for (int k = 0; k < 256 && model_p != 100; k++) begin
            @(posedge clk); #1;
            step(1'b0);
        end
        @(posedge clk); #1;
        step(1'b1);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            step($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;

        check("queue_drained", sb_q.size(), 0);
        check("anchor_p32", obs[32], 218);
        check("anchor_p64", obs[64], 254);
        check("anchor_p128", obs[128], 128);
        check("anchor_p192", obs[192], 2);
        check("anchor_p255", obs[255], 124);
        for (int p = 0; p < 128; p++) begin
            if (have_obs[p] && have_obs[p + 128]) begin
                check($sformatf("antisym_p%0d", p), obs[p + 128], 256 - obs[p]);
            end
        end
        for (int i = 1; i < 64; i++) begin
            if (have_obs[64 - i] && have_obs[64 + i]) begin
                check($sformatf("sym64_i%0d", i), obs[64 + i], obs[64 - i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
